// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core: fetch state encoding, reset vector
// and the SYSTEM opcode used by decode to recognise ECALL.
package riscv_pkg;

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        HALT
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [6:0]  OPCODE_SYSTEM    = 7'b1110011;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage against a one-cycle synchronous instruction memory,
// with a one-entry hold buffer for decode stalls, redirect on flush, and a sticky halt.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc4_o,
    output logic        halted_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  resp_pc_q, resp_pc_d;
    logic         resp_valid_q, resp_valid_d;
    logic [31:0]  hold_instr_q, hold_instr_d;

    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = resp_valid_q;
        hold_instr_d = hold_instr_q;

        unique case (state_q)
            RUN, HOLD: begin
                if (flush_i) begin
                    pc_d         = {redirect_pc_i[31:2], 2'b00};
                    resp_valid_d = 1'b0;
                    state_d      = RUN;
                end else if (halt_i && resp_valid_q) begin
                    resp_valid_d = 1'b0;
                    state_d      = HALT;
                end else if (stall_i && resp_valid_q) begin
                    // Memory moves on to pc_q next cycle, so capture the presented word now.
                    if (state_q == RUN) begin
                        hold_instr_d = imem_rdata_i;
                        state_d      = HOLD;
                    end
                end else begin
                    // pc_q is still on the address bus, so its data arrives with no bubble.
                    resp_pc_d    = pc_q;
                    resp_valid_d = 1'b1;
                    pc_d         = pc_q + 32'd4;
                    state_d      = RUN;
                end
            end
            HALT:    ;
            default: state_d = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            resp_valid_q <= 1'b0;
            hold_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    // Request is gated by reset directly so it drops the instant reset asserts.
    assign imem_req_o  = rst_ni && (state_q != HALT);
    assign imem_addr_o = pc_q;
    assign if_instr_o  = (state_q == HOLD) ? hold_instr_q : imem_rdata_i;
    assign if_pc_o     = resp_pc_q;
    assign if_pc4_o    = resp_pc_q + 32'd4;
    assign if_valid_o  = resp_valid_q;
    assign halted_o    = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table for the corner cases,
// then randomized stall/flush/halt traffic checked against a stream-level model.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i = '0;
    logic        stall_i, flush_i, halt_i;
    logic [31:0] redirect_pc_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o, if_pc_o, if_pc4_o;
    logic        halted_o;

    int total = 0;
    int bad   = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
        .stall_i(stall_i), .flush_i(flush_i), .redirect_pc_i(redirect_pc_i), .halt_i(halt_i),
        .if_valid_o(if_valid_o), .if_instr_o(if_instr_o), .if_pc_o(if_pc_o),
        .if_pc4_o(if_pc4_o), .halted_o(halted_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 | a;
    endfunction

    always @(posedge clk_i) if (imem_req_o) imem_rdata_i <= mem_word(imem_addr_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        string       name;
        logic        stall, flush, halt;
        logic [31:0] redirect;
        logic        valid;
        logic [31:0] pc;
        logic        halted;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic s, logic f, logic h, logic [31:0] rd,
                                logic v, logic [31:0] pc, logic hl);
        vec_t t;
        t.name = n; t.stall = s; t.flush = f; t.halt = h; t.redirect = rd;
        t.valid = v; t.pc = pc; t.halted = hl;
        return t;
    endfunction

    // Called right after a falling edge: drive, let one rising edge pass, check, return at falling edge.
    task automatic apply_vec(input vec_t v);
        stall_i = v.stall; flush_i = v.flush; halt_i = v.halt; redirect_pc_i = v.redirect;
        @(posedge clk_i);
        #1;
        check({v.name, "_valid"},  32'(if_valid_o), 32'(v.valid));
        check({v.name, "_pc"},     if_pc_o, v.pc);
        check({v.name, "_pc4"},    if_pc4_o, v.pc + 32'd4);
        check({v.name, "_halted"}, 32'(halted_o), 32'(v.halted));
        check({v.name, "_req"},    32'(imem_req_o), 32'(!v.halted));
        if (v.valid) check({v.name, "_instr"}, if_instr_o, mem_word(v.pc));
        @(negedge clk_i);
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) apply_vec(vecs[i]);
    endtask

    task automatic idle_inputs();
        stall_i = 1'b0; flush_i = 1'b0; halt_i = 1'b0; redirect_pc_i = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},  32'(if_valid_o), 32'd0);
        check({tag, "_req"},    32'(imem_req_o), 32'd0);
        check({tag, "_halted"}, 32'(halted_o), 32'd0);
        check({tag, "_pc"},     if_pc_o, 32'h0);
        check({tag, "_addr"},   imem_addr_o, 32'h0);
    endtask

    // Called right after a falling edge; releases reset on the next falling edge.
    task automatic do_reset(input string tag);
        rst_ni = 1'b0;
        idle_inputs();
        #1;
        check_reset_outputs(tag);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // Stream-level reference: which pc decode sees, and which address is fetched next.
    logic        m_valid, m_halted;
    logic [31:0] m_pc, m_next;

    task automatic model_reset();
        m_valid = 1'b0; m_halted = 1'b0; m_pc = 32'h0; m_next = 32'h0;
    endtask

    task automatic model_step();
        if (m_halted) return;
        if (flush_i) begin
            m_next  = redirect_pc_i & 32'hFFFF_FFFC;
            m_valid = 1'b0;
        end else if (halt_i && m_valid) begin
            m_halted = 1'b1;
            m_valid  = 1'b0;
        end else if (!(stall_i && m_valid)) begin
            m_pc    = m_next;
            m_valid = 1'b1;
            m_next  = m_next + 32'd4;
        end
    endtask

    initial begin
        // Reset release, stall/hold, flush with bubble, flush vs halt, halt stickiness.
        vecs.push_back(mk("rel0",    0, 0, 0, 32'h0,        1, 32'h00, 0));
        vecs.push_back(mk("rel1",    0, 0, 0, 32'h0,        1, 32'h04, 0));
        vecs.push_back(mk("pre_st",  0, 0, 0, 32'h0,        1, 32'h08, 0));
        vecs.push_back(mk("stall1",  1, 0, 0, 32'h0,        1, 32'h08, 0));
        vecs.push_back(mk("stall2",  1, 0, 0, 32'h0,        1, 32'h08, 0));
        vecs.push_back(mk("stall3",  1, 0, 0, 32'h0,        1, 32'h08, 0));
        vecs.push_back(mk("unstall", 0, 0, 0, 32'h0,        1, 32'h0C, 0));
        vecs.push_back(mk("at16",    0, 0, 0, 32'h0,        1, 32'h10, 0));
        vecs.push_back(mk("flush43", 0, 1, 0, 32'h43,       0, 32'h10, 0));
        vecs.push_back(mk("tgt40",   0, 0, 0, 32'h0,        1, 32'h40, 0));
        vecs.push_back(mk("fl_halt", 0, 1, 1, 32'h80,       0, 32'h40, 0));
        vecs.push_back(mk("tgt80",   0, 0, 0, 32'h0,        1, 32'h80, 0));
        vecs.push_back(mk("fl14",    0, 1, 0, 32'h14,       0, 32'h80, 0));
        vecs.push_back(mk("at20",    0, 0, 0, 32'h0,        1, 32'h14, 0));
        vecs.push_back(mk("halt",    0, 0, 1, 32'h0,        0, 32'h14, 1));
        vecs.push_back(mk("h_flush", 0, 1, 0, 32'h100,      0, 32'h14, 1));
        vecs.push_back(mk("h_misc",  1, 0, 1, 32'h200,      0, 32'h14, 1));
        // After a reset pulse: restart, wrap-around, halt/stall ignored while invalid.
        vecs.push_back(mk("rst2",    0, 0, 0, 32'h0,        1, 32'h00, 0));
        vecs.push_back(mk("flwrap",  0, 1, 0, 32'hFFFF_FFFF, 0, 32'h00, 0));
        vecs.push_back(mk("wrap_a",  0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 0));
        vecs.push_back(mk("wrap_b",  0, 0, 0, 32'h0,        1, 32'h00, 0));
        vecs.push_back(mk("fl20",    0, 1, 0, 32'h20,       0, 32'h00, 0));
        vecs.push_back(mk("halt_nv", 0, 0, 1, 32'h0,        1, 32'h20, 0));
        vecs.push_back(mk("hstall1", 1, 0, 0, 32'h0,        1, 32'h20, 0));
        vecs.push_back(mk("hstall2", 1, 0, 0, 32'h0,        1, 32'h20, 0));
        // After reset asserted mid-HOLD: no residue, then stall-while-invalid and flush from HOLD.
        vecs.push_back(mk("rst3",    0, 0, 0, 32'h0,        1, 32'h00, 0));
        vecs.push_back(mk("fl30",    0, 1, 0, 32'h30,       0, 32'h00, 0));
        vecs.push_back(mk("stall_nv",1, 0, 0, 32'h0,        1, 32'h30, 0));
        vecs.push_back(mk("hold30",  1, 0, 0, 32'h0,        1, 32'h30, 0));
        vecs.push_back(mk("hold_fl", 1, 1, 0, 32'h50,       0, 32'h30, 0));
        vecs.push_back(mk("tgt50",   0, 0, 0, 32'h0,        1, 32'h50, 0));

        rst_ni = 1'b0;
        idle_inputs();
        #1;
        check_reset_outputs("rst0");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        run_range(0, 17);
        do_reset("rst_halt");
        run_range(17, 25);

        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1 check_reset_outputs("rst_hold");
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle_inputs();
        run_range(25, vecs.size());

        do_reset("rst_rnd");
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            stall_i = ($urandom_range(0, 9) < 3);
            flush_i = ($urandom_range(0, 9) == 0);
            halt_i  = ($urandom_range(0, 29) == 0);
            redirect_pc_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                        : $urandom;
            model_step();
            @(negedge clk_i);
            check("rnd_valid",  32'(if_valid_o), 32'(m_valid));
            check("rnd_pc",     if_pc_o, m_pc);
            check("rnd_pc4",    if_pc4_o, m_pc + 32'd4);
            check("rnd_addr",   imem_addr_o, m_next);
            check("rnd_halted", 32'(halted_o), 32'(m_halted));
            check("rnd_req",    32'(imem_req_o), 32'(!m_halted));
            if (m_valid) check("rnd_instr", if_instr_o, mem_word(m_pc));
            if (m_halted && $urandom_range(0, 3) == 0) begin
                do_reset("rnd_rst");
                model_reset();
                model_step();
                @(negedge clk_i);
                check("rnd_restart_pc", if_pc_o, m_pc);
                check("rnd_restart_v",  32'(if_valid_o), 32'(m_valid));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-low reset: clk_i is the clock and rst_ni the reset.
REQ-002 The module SHALL have parameter RESET_PC, default 32'h0000_0000: word-aligned address of the first fetched instruction.
REQ-003 The module SHALL have these ports (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- imem_req_o  out  1  instruction-memory read enable
- imem_addr_o  out  32  read address; memory is synchronous, data returned the next cycle
- imem_rdata_i  in  32  read data for the address presented in the previous cycle
- stall_i  in  1  decode cannot accept; hold the current output
- flush_i  in  1  redirect request from execute (branch/jal/jalr taken)
- redirect_pc_i  in  32  redirect target
- halt_i  in  1  decode's is_halt for the currently presented instruction
- if_valid_o  out  1  if_instr_o/if_pc_o/if_pc4_o are valid
- if_instr_o  out  32  fetched instruction (opcode in [6:0] feeds the control unit)
- if_pc_o  out  32  address of if_instr_o
- if_pc4_o  out  32  if_pc_o + 4 (rd_src_optn=01 writeback source)
- halted_o  out  1  fetch permanently stopped after ECALL

Function
REQ-004 The module SHALL hold these registers: pc_q (next address to request), resp_pc_q, resp_valid_q, hold_instr_q, and state_q in {RUN, HOLD, HALT}.
REQ-005 In RUN and HOLD it SHALL drive imem_req_o=1 and imem_addr_o=pc_q. In HALT it SHALL drive imem_req_o=0 and imem_addr_o=pc_q.
REQ-006 In RUN, if_instr_o SHALL equal imem_rdata_i. In HOLD, if_instr_o SHALL equal hold_instr_q. In all states: if_pc_o=resp_pc_q, if_pc4_o=resp_pc_q+4, if_valid_o=resp_valid_q.
REQ-007 Edge priority SHALL be flush_i > halt_i (qualified by if_valid_o) > stall_i (qualified by if_valid_o) > advance.
REQ-008 On flush_i=1 in RUN or HOLD:
- pc_q<=redirect_pc_i with bits [1:0] forced to 00;
- resp_valid_q<=0;
- state<=RUN.
The target instruction SHALL appear valid two cycles after the flush cycle (exactly one bubble).
REQ-009 On halt_i=1 with if_valid_o=1 (no flush): state<=HALT, resp_valid_q<=0. HALT SHALL be sticky until reset. flush_i, stall_i and halt_i SHALL be ignored in HALT. halted_o=1 exactly when state_q==HALT.
REQ-010 On stall_i=1 with if_valid_o=1 in RUN: hold_instr_q<=imem_rdata_i, state<=HOLD, pc_q and resp_* unchanged.
REQ-011 On stall_i=1 in HOLD, all registers SHALL be unchanged.
REQ-012 Advance (RUN with no higher-priority event, or HOLD with stall_i=0):
- resp_pc_q<=pc_q;
- resp_valid_q<=1;
- pc_q<=pc_q+4;
- state<=RUN.
Leaving HOLD SHALL insert no bubble.
REQ-013 stall_i with if_valid_o=0 SHALL be treated as advance.
REQ-014 All PC arithmetic SHALL be modulo 2^32 (32'hFFFF_FFFC+4 wraps to 0). No misalignment exception.

Reset
REQ-015 While rst_ni=0, outputs SHALL be immediately forced as follows, independent of clk_i:
- state_q=RUN, pc_q=RESET_PC, resp_pc_q=RESET_PC, resp_valid_q=0, hold_instr_q=0;
- imem_req_o=0, halted_o=0, if_valid_o=0.
REQ-016 The first rising edge after rst_ni rises SHALL perform an advance. RESET_PC's instruction SHALL be valid in the second cycle after release.
REQ-017 Reset asserted mid-HOLD or in HALT SHALL discard all held state with no residual output.

Structure
REQ-018 The state enum, the default RESET_PC, and OPCODE_SYSTEM (7'b1110011) SHALL live in the shared package riscv_pkg.
REQ-019 The module SHALL be flat with no sub-module; the hold buffer and PC logic are inline.

Verification
REQ-020 The bench SHALL model a 1-cycle synchronous memory with mem[a]=32'h1000_0000|a. It SHALL cover:
- Reset release, RESET_PC=0: cycle 2 shows valid, pc=0, pc4=4; cycle 3 shows pc=4, instr=32'h1000_0004.
- stall_i high for 3 cycles while pc=8 is presented: instr 32'h1000_0008 is held stable for 3 cycles; pc=12 is valid the cycle after stall drops, no bubble.
- flush_i with redirect_pc_i=32'h0000_0043 at pc=16: next cycle valid=0; following cycle pc=32'h40, instr=32'h1000_0040.
- flush_i and halt_i together: flush wins; pc=redirect target and halted_o=0.
- halt_i at pc=20: next cycle halted_o=1, valid=0, imem_req_o=0; a later flush_i has no effect; a reset pulse restarts at RESET_PC.
- Redirect to 32'hFFFF_FFFC: next valid pc=32'hFFFF_FFFC, then pc=0.
